// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared board dimensions, count limits, FSM states and neighbour offsets
package minesweeper_pkg;

    localparam int BOARD_W   = 8;
    localparam int BOARD_H   = 8;
    localparam int X_W       = $clog2(BOARD_W);
    localparam int Y_W       = $clog2(BOARD_H);
    localparam int COUNT_W   = 4;
    localparam int MAX_COUNT = 8;
    localparam int NB_COUNT  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        WALK  = 3'b010,
        CLEAR = 3'b100
    } state_t;

    // Neighbour order: top row left to right, middle row left/right, bottom row left to right
    localparam logic signed [1:0] NB_DX [NB_COUNT] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] NB_DY [NB_COUNT] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

endpackage

// File: rtl/adjacent_count_updater_if.sv
// adjacent_count_updater_if: increment/clear requests plus the number-board access port
interface adjacent_count_updater_if
    import minesweeper_pkg::*;
#(
    parameter int XW = X_W,
    parameter int YW = Y_W,
    parameter int CW = COUNT_W
);

    logic          inc_req;
    logic [XW-1:0] inc_x;
    logic [YW-1:0] inc_y;
    logic          inc_ready;
    logic          clear_start;
    logic          clear_done;
    logic [XW-1:0] num_x;
    logic [YW-1:0] num_y;
    logic [CW-1:0] num_rd_data;
    logic [CW-1:0] num_wr_data;
    logic          num_wr_en;
    logic          busy;

    modport master (
        output inc_req, inc_x, inc_y, clear_start, num_rd_data,
        input  inc_ready, clear_done, num_x, num_y, num_wr_data, num_wr_en, busy
    );

    modport slave (
        input  inc_req, inc_x, inc_y, clear_start, num_rd_data,
        output inc_ready, clear_done, num_x, num_y, num_wr_data, num_wr_en, busy
    );

endinterface

// File: rtl/neighbour_gen.sv
// neighbour_gen: combinational neighbour coordinate and bounds check for one offset index
module neighbour_gen
    import minesweeper_pkg::*;
#(
    parameter  int boardWidth  = BOARD_W,
    parameter  int boardHeight = BOARD_H,
    localparam int XW          = $clog2(boardWidth),
    localparam int YW          = $clog2(boardHeight)
) (
    input  logic [XW-1:0] cx,
    input  logic [YW-1:0] cy,
    input  logic [2:0]    idx,
    output logic [XW-1:0] nx,
    output logic [YW-1:0] ny,
    output logic          in_bounds
);

    logic signed [XW:0] sx;
    logic signed [YW:0] sy;

    // One extra bit lets -1 show up as negative and the far-edge overflow land outside the board
    assign sx        = $signed({1'b0, cx}) + (XW+1)'(NB_DX[idx]);
    assign sy        = $signed({1'b0, cy}) + (YW+1)'(NB_DY[idx]);
    assign nx        = sx[XW-1:0];
    assign ny        = sy[YW-1:0];
    assign in_bounds = !sx[XW] && !sy[YW]
                    && (32'(sx[XW-1:0]) < 32'(boardWidth))
                    && (32'(sy[YW-1:0]) < 32'(boardHeight));

endmodule

// File: rtl/adjacent_count_updater.sv
// adjacent_count_updater: bumps the adjacency count of every neighbour of a placed mine, and clears the board
module adjacent_count_updater
    import minesweeper_pkg::*;
#(
    parameter int boardWidth  = BOARD_W,
    parameter int boardHeight = BOARD_H,
    parameter int countWidth  = COUNT_W
) (
    input logic clk,
    input logic reset,
    adjacent_count_updater_if.slave bus
);

    localparam int XW = $clog2(boardWidth);
    localparam int YW = $clog2(boardHeight);

    state_t                state, state_nx;
    logic [2:0]            idx;
    logic [XW-1:0]         ctr_x, sw_x, addr_x, nb_x;
    logic [YW-1:0]         ctr_y, sw_y, addr_y, nb_y;
    logic                  nb_in, walk_wr, sweep_last, row_last, clear_done_q;
    logic [countWidth-1:0] sat_data;

    neighbour_gen #(
        .boardWidth (boardWidth),
        .boardHeight(boardHeight)
    ) u_neighbour_gen (
        .cx       (ctr_x),
        .cy       (ctr_y),
        .idx      (idx),
        .nx       (nb_x),
        .ny       (nb_y),
        .in_bounds(nb_in)
    );

    assign row_last   = sw_x == XW'(boardWidth - 1);
    assign sweep_last = row_last && sw_y == YW'(boardHeight - 1);

    // Next state and board-port outputs; writes are gated by reset so an abort stops them at once
    always_comb begin
        walk_wr         = (state == WALK) && nb_in;
        sat_data        = (bus.num_rd_data >= countWidth'(MAX_COUNT - 1)) ? countWidth'(MAX_COUNT)
                                                                          : bus.num_rd_data + countWidth'(1);
        state_nx        = (state == IDLE)  ? (bus.clear_start ? CLEAR : bus.inc_req ? WALK : IDLE)
                        : (state == WALK)  ? (idx == 3'd7 ? IDLE : WALK)
                        : (state == CLEAR) ? (sweep_last ? IDLE : CLEAR)
                        : IDLE;
        bus.num_wr_en   = reset && (walk_wr || state == CLEAR);
        bus.num_wr_data = walk_wr ? sat_data : '0;
        bus.num_x       = walk_wr ? nb_x : (state == CLEAR) ? sw_x : addr_x;
        bus.num_y       = walk_wr ? nb_y : (state == CLEAR) ? sw_y : addr_y;
        bus.busy        = (state == WALK) || (state == CLEAR);
        bus.inc_ready   = reset && (state == IDLE) && !bus.clear_start;
        bus.clear_done  = clear_done_q;
    end

    // State register, request latch, walk index, sweep counter and held address
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            ctr_x        <= '0;
            ctr_y        <= '0;
            sw_x         <= '0;
            sw_y         <= '0;
            addr_x       <= '0;
            addr_y       <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state        <= state_nx;
            addr_x       <= bus.num_x;
            addr_y       <= bus.num_y;
            clear_done_q <= (state == CLEAR) && sweep_last;
            if (state == IDLE && bus.clear_start) begin
                sw_x <= '0;
                sw_y <= '0;
            end else if (state == IDLE && bus.inc_req) begin
                ctr_x <= bus.inc_x;
                ctr_y <= bus.inc_y;
                idx   <= '0;
            end
            if (state == WALK) idx <= idx + 3'd1;
            if (state == CLEAR) begin
                sw_x <= row_last ? '0 : sw_x + XW'(1);
                if (row_last) sw_y <= sweep_last ? '0 : sw_y + YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_adjacent_count_updater.sv
// tb_adjacent_count_updater: directed scenarios against a behavioural 8x8 number board
module tb_adjacent_count_updater;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] board [8][8];
    logic       board_zero = 1'b0;
    logic       pre_en     = 1'b0;
    logic [2:0] pre_x      = '0;
    logic [2:0] pre_y      = '0;
    logic [3:0] pre_d      = '0;

    adjacent_count_updater_if bus ();

    adjacent_count_updater dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.num_rd_data = board[bus.num_y][bus.num_x];

    always @(posedge clk) begin
        if (board_zero) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    board[y][x] <= 4'd0;
        end else if (pre_en) begin
            board[pre_y][pre_x] <= pre_d;
        end else if (bus.num_wr_en) begin
            board[bus.num_y][bus.num_x] <= bus.num_wr_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic zero_board();
        @(negedge clk);
        board_zero = 1'b1;
        @(posedge clk);
        #1 board_zero = 1'b0;
    endtask

    task automatic issue_inc(input logic [2:0] x, input logic [2:0] y);
        bus.inc_req = 1'b1;
        bus.inc_x   = x;
        bus.inc_y   = y;
        @(posedge clk);
        #1 bus.inc_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.inc_req     = 1'b0;
        bus.inc_x       = '0;
        bus.inc_y       = '0;
        bus.clear_start = 1'b0;
        reset           = 1'b0;
        repeat (2) @(posedge clk);
        zero_board();
        @(negedge clk);
        tests++;
        if ({bus.num_wr_en, bus.clear_done, bus.busy, bus.inc_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: wr_en=%b done=%b busy=%b ready=%b, want all 0",
                     bus.num_wr_en, bus.clear_done, bus.busy, bus.inc_ready);
        end
        tests++;
        if ({bus.num_x, bus.num_y, bus.num_wr_data} !== 10'd0) begin
            fails++;
            $display("FAIL reset_outputs: x=%0d y=%0d d=%0d, want 0 0 0", bus.num_x, bus.num_y, bus.num_wr_data);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.inc_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: ready=%b, want 1", bus.inc_ready);
        end
    endtask

    task automatic test_centre();
        int ex[8] = '{2, 3, 4, 2, 4, 2, 3, 4};
        int ey[8] = '{2, 2, 2, 3, 3, 4, 4, 4};
        zero_board();
        @(negedge clk);
        issue_inc(3'd3, 3'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data} !== {1'b1, 3'(ex[k]), 3'(ey[k]), 4'd1}) begin
                fails++;
                $display("FAIL centre_wr%0d: en=%b x=%0d y=%0d d=%0d, want en=1 x=%0d y=%0d d=1",
                         k, bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data, ex[k], ey[k]);
            end
            tests++;
            if ({bus.inc_ready, bus.busy} !== 2'b01) begin
                fails++;
                $display("FAIL centre_busy%0d: ready=%b busy=%b, want 0 1", k, bus.inc_ready, bus.busy);
            end
        end
        @(negedge clk);
        tests++;
        if ({bus.inc_ready, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL centre_ready9: ready=%b busy=%b, want 1 0", bus.inc_ready, bus.busy);
        end
        tests++;
        if (board[3][3] !== 4'd0) begin
            fails++;
            $display("FAIL centre_untouched: (3,3)=%0d, want 0", board[3][3]);
        end
    endtask

    task automatic test_corner();
        logic ee[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int   ex[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        int   ey[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        zero_board();
        @(negedge clk);
        issue_inc(3'd0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests++;
            if (bus.num_wr_en !== ee[k]) begin
                fails++;
                $display("FAIL corner_en%0d: en=%b, want %b", k, bus.num_wr_en, ee[k]);
            end
            if (ee[k]) begin
                tests++;
                if ({bus.num_x, bus.num_y, bus.num_wr_data} !== {3'(ex[k]), 3'(ey[k]), 4'd1}) begin
                    fails++;
                    $display("FAIL corner_wr%0d: x=%0d y=%0d d=%0d, want x=%0d y=%0d d=1",
                             k, bus.num_x, bus.num_y, bus.num_wr_data, ex[k], ey[k]);
                end
            end
            if (k == 5) begin
                tests++;
                if ({bus.num_x, bus.num_y} !== {3'd1, 3'd0}) begin
                    fails++;
                    $display("FAIL corner_addr_hold: x=%0d y=%0d, want 1 0", bus.num_x, bus.num_y);
                end
            end
        end
        @(negedge clk);
        tests++;
        if ({bus.inc_ready, bus.busy} !== 2'b10) begin
            fails++;
            $display("FAIL corner_latency: ready=%b busy=%b, want 1 0", bus.inc_ready, bus.busy);
        end
    endtask

    task automatic test_edge();
        logic ee[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   ex[8] = '{6, 7, 0, 6, 0, 6, 7, 0};
        int   ey[8] = '{3, 3, 0, 4, 0, 5, 5, 0};
        int   writes = 0;
        zero_board();
        @(negedge clk);
        issue_inc(3'd7, 3'd4);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.num_wr_en === 1'b1) writes++;
            tests++;
            if (bus.num_wr_en !== ee[k]) begin
                fails++;
                $display("FAIL edge_en%0d: en=%b, want %b", k, bus.num_wr_en, ee[k]);
            end
            if (ee[k]) begin
                tests++;
                if ({bus.num_x, bus.num_y, bus.num_wr_data} !== {3'(ex[k]), 3'(ey[k]), 4'd1}) begin
                    fails++;
                    $display("FAIL edge_wr%0d: x=%0d y=%0d d=%0d, want x=%0d y=%0d d=1",
                             k, bus.num_x, bus.num_y, bus.num_wr_data, ex[k], ey[k]);
                end
            end
        end
        @(negedge clk);
        tests++;
        if (writes != 5) begin
            fails++;
            $display("FAIL edge_write_count: writes=%0d, want 5", writes);
        end
    endtask

    task automatic test_saturation();
        int ex[8] = '{2, 3, 4, 2, 4, 2, 3, 4};
        int ey[8] = '{2, 2, 2, 3, 3, 4, 4, 4};
        int ed[8] = '{1, 1, 1, 1, 1, 1, 1, 8};
        zero_board();
        @(negedge clk);
        pre_en = 1'b1;
        pre_x  = 3'd4;
        pre_y  = 3'd4;
        pre_d  = 4'd8;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
        issue_inc(3'd3, 3'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data} !== {1'b1, 3'(ex[k]), 3'(ey[k]), 4'(ed[k])}) begin
                fails++;
                $display("FAIL sat_wr%0d: en=%b x=%0d y=%0d d=%0d, want en=1 x=%0d y=%0d d=%0d",
                         k, bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data, ex[k], ey[k], ed[k]);
            end
        end
        @(negedge clk);
        tests++;
        if ({board[4][4], board[2][2]} !== {4'd8, 4'd1}) begin
            fails++;
            $display("FAIL sat_board: (4,4)=%0d (2,2)=%0d, want 8 1", board[4][4], board[2][2]);
        end
    endtask

    task automatic test_back_to_back();
        int ex[8] = '{2, 3, 4, 2, 4, 2, 3, 4};
        int ey[8] = '{2, 2, 2, 3, 3, 4, 4, 4};
        int ed[8] = '{2, 2, 2, 2, 2, 2, 2, 8};
        tests++;
        if (bus.inc_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: ready=%b, want 1", bus.inc_ready);
        end
        issue_inc(3'd3, 3'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data} !== {1'b1, 3'(ex[k]), 3'(ey[k]), 4'(ed[k])}) begin
                fails++;
                $display("FAIL b2b_wr%0d: en=%b x=%0d y=%0d d=%0d, want en=1 x=%0d y=%0d d=%0d",
                         k, bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data, ex[k], ey[k], ed[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_clear_priority();
        int nonzero = 0;
        @(negedge clk);
        bus.clear_start = 1'b1;
        bus.inc_req     = 1'b1;
        bus.inc_x       = 3'd5;
        bus.inc_y       = 3'd2;
        @(posedge clk);
        #1 bus.clear_start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            tests++;
            if ({bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data, bus.busy, bus.clear_done}
                !== {1'b1, 3'(k % 8), 3'(k / 8), 4'd0, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL clear_cell%0d: en=%b x=%0d y=%0d d=%0d busy=%b done=%b, want en=1 x=%0d y=%0d d=0 busy=1 done=0",
                         k, bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data, bus.busy, bus.clear_done, k % 8, k / 8);
            end
        end
        @(negedge clk);
        tests++;
        if ({bus.clear_done, bus.busy, bus.inc_ready} !== 3'b101) begin
            fails++;
            $display("FAIL clear_done_pulse: done=%b busy=%b ready=%b, want 1 0 1",
                     bus.clear_done, bus.busy, bus.inc_ready);
        end
        @(posedge clk);
        #1 bus.inc_req = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.clear_done, bus.busy, bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data}
            !== {1'b0, 1'b1, 1'b1, 3'd4, 3'd1, 4'd1}) begin
            fails++;
            $display("FAIL clear_then_inc: done=%b busy=%b en=%b x=%0d y=%0d d=%0d, want 0 1 1 4 1 1",
                     bus.clear_done, bus.busy, bus.num_wr_en, bus.num_x, bus.num_y, bus.num_wr_data);
        end
        repeat (8) @(negedge clk);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (board[y][x] !== 4'd0) nonzero++;
        tests++;
        if (nonzero != 8 || board[2][5] !== 4'd0) begin
            fails++;
            $display("FAIL clear_board: nonzero=%0d (5,2)=%0d, want 8 0", nonzero, board[2][5]);
        end
    endtask

    task automatic test_reset_mid_walk();
        int ex[8] = '{2, 3, 4, 2, 4, 2, 3, 4};
        int ey[8] = '{2, 2, 2, 3, 3, 4, 4, 4};
        zero_board();
        @(negedge clk);
        issue_inc(3'd3, 3'd3);
        repeat (3) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (bus.num_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_wr_gate: en=%b, want 0", bus.num_wr_en);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({bus.busy, bus.inc_ready, bus.num_wr_en} !== 3'b000) begin
                fails++;
                $display("FAIL abort_idle%0d: busy=%b ready=%b en=%b, want 0 0 0",
                         c, bus.busy, bus.inc_ready, bus.num_wr_en);
            end
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (board[ey[k]][ex[k]] !== ((k < 3) ? 4'd1 : 4'd0)) begin
                fails++;
                $display("FAIL abort_cell%0d: (%0d,%0d)=%0d, want %0d",
                         k, ex[k], ey[k], board[ey[k]][ex[k]], (k < 3) ? 1 : 0);
            end
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.inc_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_release: ready=%b, want 1", bus.inc_ready);
        end
    endtask

    initial begin
        test_reset();
        test_centre();
        test_corner();
        test_edge();
        test_saturation();
        test_back_to_back();
        test_clear_priority();
        test_reset_mid_walk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adjacent_count_updater.md
Name: adjacent_count_updater

Overview:
- Responder on the number-board side of the mine-placement interface.
- Accepts one increment request per placed mine at (inc_x, inc_y).
- Walks all 8 neighbours of that cell and does a read-modify-write +1 on each in-bounds neighbour's adjacency count.
- Also provides a whole-board clear sweep used before a new game's placement pass.

Parameters:
- boardWidth, 8, columns on the board.
- boardHeight, 8, rows on the board.
- countWidth, 4, bits per adjacency count; holds 0..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- inc_req  in  1  increment request; requester holds it until accepted
- inc_x  in  $clog2(boardWidth)  column of the newly placed mine
- inc_y  in  $clog2(boardHeight)  row of the newly placed mine
- inc_ready  out  1  high only in IDLE; a request is accepted when inc_req && inc_ready
- clear_start  in  1  request to zero the whole number board
- clear_done  out  1  one-cycle pulse when the clear sweep completes
- num_x  out  $clog2(boardWidth)  shared read/write column address
- num_y  out  $clog2(boardHeight)  shared read/write row address
- num_rd_data  in  countWidth  combinational read of the count at (num_x, num_y)
- num_wr_data  out  countWidth  write data
- num_wr_en  out  1  write strobe; the board captures on the next clk edge
- busy  out  1  high in WALK or CLEAR

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE, neighbour index to 0, latched centre to 0.
  - Outputs: num_wr_en=0, clear_done=0, busy=0, num_x=0, num_y=0, num_wr_data=0.
  - inc_ready=0 while reset is held; it goes to 1 on the first cycle after release.
- Reset mid-WALK or mid-CLEAR aborts immediately: no further writes, and partial updates are left in place.
- State machine: one-hot, states IDLE, WALK, CLEAR.
- IDLE:
  - If clear_start: go to CLEAR with sweep counter 0. clear_start has priority over inc_req in the same cycle, and the request is not accepted.
  - Else if inc_req: latch inc_x/inc_y, set index 0, go to WALK.
- WALK: one neighbour per cycle, index 0..7. Offsets (dx,dy) in order:
  - 0: (-1,-1), 1: (0,-1), 2: (+1,-1), 3: (-1,0)
  - 4: (+1,0), 5: (-1,+1), 6: (0,+1), 7: (+1,+1)
- WALK arithmetic:
  - Neighbour coordinate is computed signed, one bit wider than the coordinate.
  - In-bounds means 0 <= nx < boardWidth and 0 <= ny < boardHeight.
  - In-bounds: num_x/num_y = neighbour, num_wr_en=1, num_wr_data = num_rd_data+1, saturating at 8 (a count of 8 or more writes 8).
  - Out-of-bounds: num_wr_en=0 and the address holds its previous value.
  - The centre cell is never written.
- WALK timing:
  - Fixed latency of 8 cycles per request, independent of position on the board.
  - After index 7, return to IDLE; inc_ready is high on the next cycle.
  - Minimum request spacing is 9 cycles.
- CLEAR:
  - Row-major sweep over all boardWidth*boardHeight cells, writing 0 to each, one cell per cycle.
  - After the last cell, clear_done=1 for exactly one cycle, in the first IDLE cycle.
  - inc_req and clear_start are ignored while in WALK or CLEAR.
- Outputs num_wr_en and num_wr_data are combinational from state, index and num_rd_data. The addresses come from registered state and the neighbour generator.

Decomposition:
- Package minesweeper_pkg holds:
  - board dimension constants and coordinate widths
  - COUNT_W=4 and MAX_COUNT=8
  - state encodings
  - the 8-entry neighbour offset table
- One natural sub-module: neighbour_gen. It is combinational: inputs are centre x/y and index; outputs are nx, ny and in_bounds. It will be reused by the reveal/flood-fill block.

Test Plan:
- Board all zero, inc at (3,3): 8 consecutive writes to the 8 neighbours with data 1; (3,3) untouched; inc_ready low for 8 cycles, high on cycle 9.
- Corner inc at (0,0): writes only at (1,0), (0,1), (1,1); num_wr_en is low in the other 5 WALK cycles; total latency is still 8.
- Edge inc at (7,4) on 8x8: exactly 5 writes, to (6,3), (7,3), (6,4), (6,5), (7,5).
- Saturation: preload (4,4)=8, inc at (3,3) -> (4,4) is written with 8 and stays 8; the other neighbours are written with 1.
- clear_start and inc_req asserted together in IDLE -> CLEAR wins; 64 zero writes at (0,0)..(7,7); clear_done pulses once; the held inc_req is then accepted in the following IDLE cycle.
- reset=0 in the cycle where WALK index is 3 -> IDLE the next cycle, num_wr_en=0, and indices 3..7 are never written; busy=0 and inc_ready=0 until reset is released.
